mod_p_arbiter: RTL and testbench
================================

// Module: mod_p_arbiter
// PURPOSE
//   Shares one combinational mod_P reducer between N_REQ requesters with valid/ready handshakes.
//   Requesters are served round-robin. The result is registered with the requester index as a tag.
//   Owns the d x 8 redundancy matrix B. Reloads it safely: new grants stop, the output drains, then B is swapped.
//   Sits between the masked-state producers (S-box / mixing lanes) and the unmasking / syndrome-check logic.
// PARAMETERS
//   d       8  redundancy bits per codeword; state_t is [0:7+d], dm_matrix_t is d rows x 8 bits
//   N_REQ   4  number of requesters, >= 2; TAG_W = $clog2(N_REQ)
// PORTS
//   clk        in   1            single clock, all state on rising edge
//   rst        in   1            synchronous, active-high reset
//   req_valid  in   N_REQ        requester i has a codeword
//   req_data   in   N_REQ x 8+d  state_t per requester
//   req_ready  out  N_REQ        one-hot grant; transfer when req_valid[i] & req_ready[i]
//   out_valid  out  1            result register full
//   out_data   out  8            mod_P(granted codeword, B_reg)
//   out_tag    out  TAG_W        index of requester that produced out_data
//   out_ready  in   1            consumer accepts when out_valid & out_ready
//   b_load     in   1            single-cycle request to replace B
//   b_in       in   d x 8        new B (dm_matrix_t), sampled in the b_load cycle
//   b_ack      out  1            1-cycle pulse when B_reg takes the new value
//   busy_cfg   out  1            high while FSM is not RUN
// BEHAVIOUR
//   Reset: out_valid=0, out_data=0, out_tag=0, req_ready=0, b_ack=0, busy_cfg=0.
//   Reset also sets: B_reg=0 (pass-through: out=in[0:7]), rr_ptr=0, FSM=RUN, B_shadow=0.
//   Reduction: out[i] = in[i] ^ XOR_j(B_reg[j][i] & in[8+j]), with i in 0..7 and j in 0..d-1.
//     One internal mod_P instance is computed on the granted req_data, using B_reg.
//   slot_free = !out_valid | out_ready.
//   RUN, grant rule:
//     - If slot_free, grant the first valid i searching from rr_ptr upward with wrap.
//     - Grant is combinational, in the same cycle. req_ready has at most one bit set.
//     - req_ready=0 when there is no valid request or no free slot.
//   On a transfer:
//     - out_data and out_tag are loaded at the edge.
//     - out_valid=1.
//     - rr_ptr <= granted+1, wrapping N_REQ-1 -> 0.
//     - Latency from transfer to out_valid is 1 cycle.
//     - Full throughput: one result per cycle while out_ready=1.
//   Output hold: if out_valid & !out_ready, out_data and out_tag stay stable and there is no grant.
//   Output drain: if out_ready & no grant, out_valid <= 0.
//   The registered result keeps the B value used at grant time, even if B_reg changes later.
//   FSM, RUN -> DRAIN:
//     - Taken on b_load. b_in is latched into B_shadow.
//     - Grants are already suppressed in the b_load cycle.
//   FSM, DRAIN:
//     - No grants. Waits until out_valid=0, or until out_valid & out_ready is seen at an edge.
//     - Then -> LOAD.
//   FSM, LOAD:
//     - B_reg <= B_shadow, b_ack=1 for this cycle, then -> RUN.
//     - The first grant using the new B is in the cycle after LOAD.
//   busy_cfg=1 in DRAIN and LOAD.
//   b_load while not in RUN is ignored: no re-latch and no extra b_ack.
//   Reset in any state returns to the reset values above on the next edge. Any in-flight result is discarded.
//   rr_ptr does not advance while in DRAIN or LOAD.
// TESTING
//   1. After reset, B=0. req_valid=0001, req_data[0]=0x3A_FF (d=8).
//      -> req_ready=0001 same cycle. Next cycle out_valid=1, out_data=0x3A, out_tag=0.
//   2. Load B with every row=0x01. Send data byte 0x00, redundancy 0x03 (two bits set).
//      -> out_data=0x00 (XOR of two 0x01 rows). With redundancy 0x01 -> out_data=0x01.
//   3. req_valid=1111 held, out_ready=1.
//      -> grants 0,1,2,3,0,... one per cycle; out_tag follows one cycle later.
//   4. out_ready=0 with out_valid=1 for 5 cycles, other requesters valid.
//      -> out_data and out_tag stable, req_ready=0. On release, the held result drains and the next rr grant occurs in the same cycle.
//   5. b_load with out_valid=1, out_ready=0 for 3 cycles.
//      -> busy_cfg=1 and no grants. One cycle after the drain, b_ack pulses. Results granted afterwards use the new B. The held result reflects the old B.
//   6. rst asserted in DRAIN with out_valid=1.
//      -> next cycle all outputs 0, B_reg=0, FSM=RUN, grant restarts from requester 0.

Source files
------------

// File: rtl/mod_p_arbiter.sv
// Round-robin arbiter sharing one mod_P reducer between N_REQ requesters.
// Owns the d x 8 redundancy matrix B and swaps it only after the output
// register has drained, so every result reflects the B in force at grant time.
//
// Bit layout (big-endian, matching state_t [0:7+d]):
//   requester i word : req_data[i*(8+d) +: 8+d]; in[k] sits at word bit (7+d-k),
//                      so the data byte is the upper 8 bits, redundancy the lower d.
//   B row j          : b_in[(d-1-j)*8 +: 8]; row bit i sits at byte bit (7-i).
//   out_data         : out[i] sits at out_data bit (7-i).
module mod_p_arbiter #(
  parameter int unsigned d     = 8,
  parameter int unsigned N_REQ = 4,
  localparam int unsigned TAG_W = $clog2(N_REQ),
  localparam int unsigned W     = 8 + d
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ*W-1:0]   req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 out_valid,
  output logic [7:0]           out_data,
  output logic [TAG_W-1:0]     out_tag,
  input  logic                 out_ready,
  input  logic                 b_load,
  input  logic [d*8-1:0]       b_in,
  output logic                 b_ack,
  output logic                 busy_cfg
);

  typedef enum logic [1:0] {RUN, DRAIN, LOAD} fsm_t;

  fsm_t             state, state_nxt;
  logic [TAG_W-1:0] rr_ptr;
  logic [d*8-1:0]   b_reg;
  logic [d*8-1:0]   b_shadow;

  logic             slot_free;
  logic             found;
  logic [TAG_W-1:0] gnt_idx;
  logic [TAG_W-1:0] cand;
  logic [W-1:0]     sel_word;
  logic [7:0]       reduced;

  assign slot_free = !out_valid || out_ready;
  assign busy_cfg  = (state != RUN);
  assign b_ack     = (state == LOAD);

  // Round-robin search from rr_ptr; grants are blocked outside RUN and in the b_load cycle
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (!rst && state == RUN && !b_load && slot_free) begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        cand = TAG_W'((32'(rr_ptr) + k) % N_REQ);
        if (!found && req_valid[cand]) begin
          found   = 1'b1;
          gnt_idx = cand;
        end
      end
    end
    req_ready = found ? (N_REQ'(1) << gnt_idx) : '0;
  end

  // mod_P on the granted word: data byte XOR the B rows selected by set redundancy bits.
  // Word bit k carries in[7+d-k], i.e. redundancy index j=d-1-k, whose row lives at b_reg[k*8 +: 8].
  always_comb begin
    sel_word = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt_idx == TAG_W'(i)) sel_word = req_data[i*W +: W];
    end
    reduced = sel_word[W-1:d];
    for (int unsigned k = 0; k < d; k++) begin
      if (sel_word[k]) reduced = reduced ^ b_reg[k*8 +: 8];
    end
  end

  // Config FSM: RUN -> DRAIN on b_load, DRAIN -> LOAD once the output slot empties, LOAD -> RUN
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (b_load) state_nxt = DRAIN;
      DRAIN:   if (!out_valid || out_ready) state_nxt = LOAD;
      LOAD:    state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // State, matrix and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      rr_ptr    <= '0;
      b_reg     <= '0;
      b_shadow  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
    end else begin
      state <= state_nxt;
      if (state == RUN && b_load) b_shadow <= b_in;
      if (state == LOAD) b_reg <= b_shadow;
      if (found) begin
        out_valid <= 1'b1;
        out_data  <= reduced;
        out_tag   <= gnt_idx;
        rr_ptr    <= (gnt_idx == TAG_W'(N_REQ - 1)) ? '0 : gnt_idx + TAG_W'(1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mod_p_arbiter.sv
// Self-checking bench for mod_p_arbiter (d=8, N_REQ=4): directed vector table,
// hand sequences for config reload and reset, then random traffic vs a reference model.
module tb_mod_p_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_tag;
  logic        out_ready;
  logic        b_load;
  logic [63:0] b_in;
  logic        b_ack;
  logic        busy_cfg;

  always #5 clk = ~clk;

  mod_p_arbiter #(.d(8), .N_REQ(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
    .out_tag(out_tag), .out_ready(out_ready), .b_load(b_load), .b_in(b_in),
    .b_ack(b_ack), .busy_cfg(busy_cfg)
  );

  typedef struct {
    bit          chk_exp;
    logic        rst;
    logic [3:0]  rv;
    logic [63:0] data;
    logic        ordy;
    logic        bload;
    logic [63:0] bin;
    logic [3:0]  e_rdy;
    logic        e_ov;
    logic [7:0]  e_od;
    logic [1:0]  e_tag;
    logic        e_ack;
    logic        e_busy;
  } t_vec;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain description of the arbiter's observable behaviour
  int          m_rr, m_tag, m_phase;   // phase: 0 serving, 1 waiting for empty slot, 2 swapping B
  bit          m_ov;
  logic [7:0]  m_od;
  logic [63:0] m_b, m_sh;

  function automatic t_vec mk(bit chk, logic r, logic [3:0] rv, logic [63:0] data,
                              logic ordy, logic bl, logic [63:0] bin,
                              logic [3:0] erdy, logic eov, logic [7:0] eod,
                              logic [1:0] etag, logic eack, logic ebusy);
    t_vec v;
    v.chk_exp = chk; v.rst = r; v.rv = rv; v.data = data; v.ordy = ordy;
    v.bload = bl; v.bin = bin; v.e_rdy = erdy; v.e_ov = eov; v.e_od = eod;
    v.e_tag = etag; v.e_ack = eack; v.e_busy = ebusy;
    return v;
  endfunction

  // out[i] = in[i] ^ XOR_j(B[j][i] & in[8+j]); in[8+j] is word bit 7-j, row j is B[(7-j)*8 +: 8]
  function automatic logic [7:0] ref_mod(logic [15:0] w, logic [63:0] b);
    logic [7:0] r = w[15:8];
    for (int j = 0; j < 8; j++)
      if (w[7-j]) r = r ^ b[(7-j)*8 +: 8];
    return r;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic vec(t_vec v, bit chk_model);
    int gnt;
    logic [3:0] m_rdy;
    @(negedge clk);
    rst = v.rst; req_valid = v.rv; req_data = v.data;
    out_ready = v.ordy; b_load = v.bload; b_in = v.bin;
    #1;
    gnt = -1;
    if (!v.rst && m_phase == 0 && !v.bload && (!m_ov || v.ordy))
      for (int k = 0; k < 4; k++)
        if (gnt < 0 && v.rv[(m_rr + k) % 4]) gnt = (m_rr + k) % 4;
    m_rdy = (gnt >= 0) ? 4'(1 << gnt) : 4'b0;
    if (chk_model) begin
      check("model req_ready", req_ready, m_rdy);
      check("model out_valid", out_valid, m_ov);
      check("model out_data",  out_data,  m_od);
      check("model out_tag",   out_tag,   m_tag);
      check("model b_ack",     b_ack,     m_phase == 2);
      check("model busy_cfg",  busy_cfg,  m_phase != 0);
    end
    if (v.chk_exp) begin
      check("vec req_ready", req_ready, v.e_rdy);
      check("vec out_valid", out_valid, v.e_ov);
      check("vec out_data",  out_data,  v.e_od);
      check("vec out_tag",   out_tag,   v.e_tag);
      check("vec b_ack",     b_ack,     v.e_ack);
      check("vec busy_cfg",  busy_cfg,  v.e_busy);
    end
    @(posedge clk);
    if (v.rst) begin
      m_rr = 0; m_tag = 0; m_phase = 0; m_ov = 0; m_od = 8'h00; m_b = '0; m_sh = '0;
    end else begin
      case (m_phase)
        0: if (v.bload) begin m_sh = v.bin; m_phase = 1; end
        1: if (!m_ov || v.ordy) m_phase = 2;
        default: begin m_b = m_sh; m_phase = 0; end
      endcase
      if (gnt >= 0) begin
        m_ov = 1; m_od = ref_mod(v.data[gnt*16 +: 16], m_b); m_tag = gnt; m_rr = (gnt + 1) % 4;
      end else if (v.ordy) begin
        m_ov = 0;
      end
    end
  endtask

  localparam logic [63:0] ROWS01 = 64'h0101_0101_0101_0101;
  localparam logic [63:0] ROWSW  = 64'h8040_2010_0804_0201;
  localparam logic [63:0] D3     = 64'h1300_1200_1100_1000;

  t_vec tbl[$];

  initial begin
    m_rr = 0; m_tag = 0; m_phase = 0; m_ov = 0; m_od = 0; m_b = '0; m_sh = '0;
    rst = 1; req_valid = 0; req_data = 0; out_ready = 1; b_load = 0; b_in = 0;
    // settle reset without checks
    repeat (2) vec(mk(0, 1, 4'h0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), 0);

    //           chk rst rv     data                  ordy bl bin     rdy   ov od     tag ack busy
    tbl.push_back(mk(1, 1, 4'h1, 64'h3AFF,             1,  0, 0,      4'h0, 0, 8'h00, 0, 0, 0)); // reset state, grant gated
    tbl.push_back(mk(1, 0, 4'h1, 64'h3AFF,             1,  0, 0,      4'h1, 0, 8'h00, 0, 0, 0)); // same-cycle grant
    tbl.push_back(mk(1, 0, 4'h0, 0,                    1,  0, 0,      4'h0, 1, 8'h3A, 0, 0, 0)); // pass-through B=0
    tbl.push_back(mk(1, 0, 4'h0, 0,                    1,  1, ROWS01, 4'h0, 0, 8'h3A, 0, 0, 0)); // b_load
    tbl.push_back(mk(1, 0, 4'h1, 64'h0003,             1,  0, 0,      4'h0, 0, 8'h3A, 0, 0, 1)); // drain
    tbl.push_back(mk(1, 0, 4'h1, 64'h0003,             1,  0, 0,      4'h0, 0, 8'h3A, 0, 1, 1)); // load
    tbl.push_back(mk(1, 0, 4'h1, 64'h0003,             1,  0, 0,      4'h1, 0, 8'h3A, 0, 0, 0)); // rr wraps to 0
    tbl.push_back(mk(1, 0, 4'h1, 64'h0001,             1,  0, 0,      4'h1, 1, 8'h00, 0, 0, 0)); // two rows cancel
    tbl.push_back(mk(1, 0, 4'h0, 0,                    1,  0, 0,      4'h0, 1, 8'h01, 0, 0, 0)); // one row
    tbl.push_back(mk(1, 0, 4'hF, D3,                   1,  0, 0,      4'h2, 0, 8'h01, 0, 0, 0)); // round robin
    tbl.push_back(mk(1, 0, 4'hF, D3,                   1,  0, 0,      4'h4, 1, 8'h11, 1, 0, 0));
    tbl.push_back(mk(1, 0, 4'hF, D3,                   1,  0, 0,      4'h8, 1, 8'h12, 2, 0, 0));
    tbl.push_back(mk(1, 0, 4'hF, D3,                   1,  0, 0,      4'h1, 1, 8'h13, 3, 0, 0));
    tbl.push_back(mk(1, 0, 4'hF, D3,                   1,  0, 0,      4'h2, 1, 8'h10, 0, 0, 0));
    for (int i = 0; i < 5; i++)                                                                // hold
      tbl.push_back(mk(1, 0, 4'hF, D3,                 0,  0, 0,      4'h0, 1, 8'h11, 1, 0, 0));
    tbl.push_back(mk(1, 0, 4'hF, D3,                   1,  0, 0,      4'h4, 1, 8'h11, 1, 0, 0)); // release + grant
    tbl.push_back(mk(1, 0, 4'h0, 0,                    1,  0, 0,      4'h0, 1, 8'h12, 2, 0, 0));
    foreach (tbl[i]) vec(tbl[i], 1);

    // B reload while the output is held: old result keeps old B, later result uses new B
    vec(mk(1, 0, 4'h1, 64'h5503, 0, 0, 0,         4'h1, 0, 8'h12, 2, 0, 0), 1);
    vec(mk(1, 0, 4'hF, D3,       0, 1, ROWSW,     4'h0, 1, 8'h55, 0, 0, 0), 1);
    vec(mk(1, 0, 4'hF, D3,       0, 1, '1,        4'h0, 1, 8'h55, 0, 0, 1), 1); // ignored re-load
    vec(mk(1, 0, 4'hF, D3,       0, 0, 0,         4'h0, 1, 8'h55, 0, 0, 1), 1);
    vec(mk(1, 0, 4'hF, D3,       1, 0, 0,         4'h0, 1, 8'h55, 0, 0, 1), 1);
    vec(mk(1, 0, 4'hF, D3,       1, 0, 0,         4'h0, 0, 8'h55, 0, 1, 1), 1);
    vec(mk(1, 0, 4'h1, 64'h0003, 1, 0, 0,         4'h1, 0, 8'h55, 0, 0, 0), 1);
    vec(mk(1, 0, 4'h0, 0,        0, 0, 0,         4'h0, 1, 8'h03, 0, 0, 0), 1);
    // reset while draining with a held result
    vec(mk(1, 0, 4'h0, 0,        0, 1, ROWS01,    4'h0, 1, 8'h03, 0, 0, 0), 1);
    vec(mk(1, 1, 4'hF, D3,       0, 0, 0,         4'h0, 1, 8'h03, 0, 0, 1), 1);
    vec(mk(1, 0, 4'hF, 64'h4400_4300_4200_41FF, 1, 0, 0, 4'h1, 0, 8'h00, 0, 0, 0), 1);
    vec(mk(1, 0, 4'h0, 0,        1, 0, 0,         4'h0, 1, 8'h41, 0, 0, 0), 1);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      t_vec v;
      v = mk(0, ($urandom_range(0, 99) == 0), 4'($urandom), {$urandom, $urandom},
             ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0), {$urandom, $urandom},
             0, 0, 0, 0, 0, 0);
      vec(v, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
